// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port data memory between two requesters.
//   Port 0 is the pipeline load/store path, port 1 the debug/DMA loader.
//   Round-robin arbitration, with each access held on the memory pins for
//   WAIT_CYCLES+1 cycles, followed by a one-cycle ack pulse to the winner.
//
// Ports
//   clk, rst                       clock (rising edge), async active-high reset
//   req/we/addr/wdata{0,1}         requester inputs, held stable until ack
//   rdata{0,1}                     per-port read data, updated only by that port's reads
//   ack{0,1}                       one-cycle completion pulse
//   mem_read/mem_write             memory strobes (write strobe only in the last access cycle)
//   mem_address/mem_writedata      memory pins, always driven from latched registers
//   mem_readdata                   combinational read data from the memory
//   busy                           high whenever the arbiter is not idle
module mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack1,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                gnt_q, gnt_d;
  logic                we_q, we_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                sel;

  // Lone requester wins; on a tie the port not served last time wins.
  assign sel = (req0 && req1) ? ~last_q : req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = sel;
          we_d    = sel ? we1    : we0;
          addr_d  = sel ? addr1  : addr0;
          wdata_d = sel ? wdata1 : wdata0;
          cnt_d   = CNT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          // Read data is captured on the edge that leaves ACCESS.
          if (!we_q) begin
            if (gnt_q) rdata1_d = mem_readdata;
            else       rdata0_d = mem_readdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All memory-side outputs derive from registers only, so requester inputs
  // never reach the memory pins combinationally. The write strobe is limited
  // to the final access cycle so the memory sees exactly one write edge, and
  // it drops with the async reset because it decodes state_q directly.
  assign mem_read      = (state_q == S_ACCESS) && !we_q;
  assign mem_write     = (state_q == S_ACCESS) && we_q && (cnt_q == 4'd0);
  assign mem_address   = addr_q;
  assign mem_writedata = wdata_q;
  assign ack0          = (state_q == S_DONE) && !gnt_q;
  assign ack1          = (state_q == S_DONE) && gnt_q;
  assign busy          = (state_q != S_IDLE);
  assign rdata0        = rdata0_q;
  assign rdata1        = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two DUT instances (WAIT_CYCLES 1 and 3), each with a
// memory model. A single stimulus process drives directed and random request
// streams; a single monitor records requests as they appear, pops them on ack
// and checks grant order, timing, memory pin activity and read data against a
// reference memory updated in completion order.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            raise;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic [DW-1:0] rdata [2][2];
  logic          ack   [2][2];
  logic          mem_read [2];
  logic          mem_write [2];
  logic [AW-1:0] mem_address [2];
  logic [DW-1:0] mem_writedata [2];
  logic [DW-1:0] mem_readdata [2];
  logic          busy [2];
  bit   [DW-1:0] mem [2][65536];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(gi == 0 ? 1 : 3)) dut (
      .clk(clk), .rst(rst),
      .req0(req[gi][0]), .we0(we[gi][0]), .addr0(addr[gi][0]), .wdata0(wdata[gi][0]),
      .rdata0(rdata[gi][0]), .ack0(ack[gi][0]),
      .req1(req[gi][1]), .we1(we[gi][1]), .addr1(addr[gi][1]), .wdata1(wdata[gi][1]),
      .rdata1(rdata[gi][1]), .ack1(ack[gi][1]),
      .mem_read(mem_read[gi]), .mem_write(mem_write[gi]),
      .mem_address(mem_address[gi]), .mem_writedata(mem_writedata[gi]),
      .mem_readdata(mem_readdata[gi]), .busy(busy[gi])
    );
    assign mem_readdata[gi] = mem[gi][mem_address[gi]];
  end

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (mem_write[i]) mem[i][mem_address[i]] <= mem_writedata[i];

  function automatic int wc_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  txn_t          sb [4][$];
  bit   [DW-1:0] ref_mem [2][65536];
  logic [DW-1:0] exp_rd [2][2];
  int            rd_cnt [2], wr_cnt [2], wr_cyc [2], last_port [2], last_ack_cyc [2];
  logic [AW-1:0] rd_addr [2], wr_addr [2];
  logic [DW-1:0] wr_data [2];
  bit            done = 1'b0;
  bit            reported = 1'b0;
  int            tmo_cnt = 0;

  task automatic chk(input int i, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d cyc%0d: got %0h, expected %0h", name, i, cyc, act, exp);
    end
  endtask

  task automatic mon(input int i);
    txn_t t;
    int   g, q, exp_g;
    int   wc = wc_of(i);
    if (rst) begin
      chk(i, "reset_strobes", 64'({mem_read[i], mem_write[i], busy[i], ack[i][0], ack[i][1]}), 64'd0);
      chk(i, "reset_mem_pins", 64'({mem_address[i], mem_writedata[i]}), 64'd0);
      chk(i, "reset_rdata", 64'({rdata[i][0], rdata[i][1]}), 64'd0);
      for (int p = 0; p < 2; p++) begin
        sb[i*2+p].delete();
        exp_rd[i][p] = '0;
      end
      rd_cnt[i] = 0; wr_cnt[i] = 0; last_port[i] = 1; last_ack_cyc[i] = cyc - 1;
      return;
    end
    if (mem_read[i])  begin rd_cnt[i]++; rd_addr[i] = mem_address[i]; end
    if (mem_write[i]) begin wr_cnt[i]++; wr_cyc[i] = cyc; wr_addr[i] = mem_address[i]; wr_data[i] = mem_writedata[i]; end
    for (int p = 0; p < 2; p++) begin
      if (ack[i][p]) begin
        chk(i, $sformatf("ack_exclusive_p%0d", p), 64'(ack[i][1-p]), 64'd0);
        chk(i, "busy_at_ack", 64'(busy[i]), 64'd1);
        if (sb[i*2+p].size() == 0) begin
          chk(i, $sformatf("spurious_ack_p%0d", p), 64'd1, 64'd0);
        end else begin
          t = sb[i*2+p].pop_front();
          g = cyc - wc - 1;
          q = 1 - p;
          if (sb[i*2+q].size() > 0 && sb[i*2+q][0].raise < g)
            chk(i, "rr_grant", 64'(p), 64'((last_port[i] == p) ? q : p));
          exp_g = (t.raise + 1 > last_ack_cyc[i] + 2) ? t.raise + 1 : last_ack_cyc[i] + 2;
          chk(i, $sformatf("grant_edge_p%0d", p), 64'(g), 64'(exp_g));
          if (t.we) begin
            chk(i, "wr_strobe_count", 64'(wr_cnt[i]), 64'd1);
            chk(i, "wr_last_cycle", 64'(wr_cyc[i]), 64'(cyc - 1));
            chk(i, "wr_addr", 64'(wr_addr[i]), 64'(t.addr));
            chk(i, "wr_data", 64'(wr_data[i]), 64'(t.data));
            chk(i, "rd_strobe_in_wr", 64'(rd_cnt[i]), 64'd0);
            ref_mem[i][t.addr] = t.data;
          end else begin
            chk(i, "rd_strobe_count", 64'(rd_cnt[i]), 64'(wc + 1));
            chk(i, "wr_strobe_in_rd", 64'(wr_cnt[i]), 64'd0);
            chk(i, "rd_addr", 64'(rd_addr[i]), 64'(t.addr));
            exp_rd[i][p] = ref_mem[i][t.addr];
          end
          last_port[i] = p; last_ack_cyc[i] = cyc; rd_cnt[i] = 0; wr_cnt[i] = 0;
        end
      end
    end
    for (int p = 0; p < 2; p++)
      chk(i, $sformatf("rdata_p%0d", p), 64'(rdata[i][p]), 64'(exp_rd[i][p]));
    // A request is recorded the first time it is seen while nothing is outstanding.
    for (int p = 0; p < 2; p++)
      if (req[i][p] && sb[i*2+p].size() == 0) begin
        t.we = we[i][p]; t.addr = addr[i][p]; t.data = wdata[i][p]; t.raise = cyc;
        sb[i*2+p].push_back(t);
      end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) mon(i);
    if (done && !reported) begin
      chk(0, "timeouts", 64'(tmo_cnt), 64'd0);
      for (int k = 0; k < 4; k++) chk(k / 2, "sb_drained", 64'(sb[k].size()), 64'd0);
      reported = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  txn_t plan [2][$];

  function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.data = d; t.raise = 0;
    return t;
  endfunction

  task automatic issue(input int i, input int p, input txn_t t);
    we[i][p] = t.we; addr[i][p] = t.addr; wdata[i][p] = t.data; req[i][p] = 1'b1;
  endtask

  // Runs both ports' plans on instance i; a requester drops req on seeing ack
  // and waits 0..gmax cycles before its next request.
  task automatic run(input int i, input int gmax);
    int   gap [2] = '{0, 0};
    int   budget = 3000;
    txn_t t;
    forever begin
      for (int p = 0; p < 2; p++) begin
        if (req[i][p] && ack[i][p]) begin
          req[i][p] = 1'b0;
          gap[p] = $urandom_range(0, gmax);
        end
        if (!req[i][p]) begin
          if (gap[p] > 0) gap[p]--;
          else if (plan[p].size() > 0) begin t = plan[p].pop_front(); issue(i, p, t); end
        end
      end
      if (!req[i][0] && !req[i][1] && plan[0].size() == 0 && plan[1].size() == 0) break;
      budget--;
      if (budget == 0) begin
        $display("FAIL timeout inst%0d: requests still pending after 3000 cycles, required completion", i);
        tmo_cnt++;
        for (int p = 0; p < 2; p++) begin req[i][p] = 1'b0; plan[p].delete(); end
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic program_inst(input int i);
    logic [AW-1:0] a;
    do_reset();
    // Simultaneous reads straight after reset: port 0 must win.
    plan[0].push_back(mk(1'b0, 16'h0010, '0));
    plan[1].push_back(mk(1'b0, 16'h0010, '0));
    run(i, 0);
    // Port 0 write then readback.
    plan[0].push_back(mk(1'b1, 16'h0010, 32'hDEADBEEF));
    plan[0].push_back(mk(1'b0, 16'h0010, '0));
    run(i, 0);
    // Port 1 reads a known value, then writes; rdata1 must hold.
    plan[0].push_back(mk(1'b1, 16'h0040, 32'h12345678));
    run(i, 0);
    plan[1].push_back(mk(1'b0, 16'h0040, '0));
    plan[1].push_back(mk(1'b1, 16'h0044, 32'hCAFEF00D));
    run(i, 0);
    // Reset during the first access cycle of a write must not commit it.
    plan[0].push_back(mk(1'b1, 16'h0020, 32'hAAAA5555));
    run(i, 0);
    issue(i, 0, mk(1'b1, 16'h0020, 32'hBADBAD00));
    @(posedge clk);
    #2 rst = 1'b1;
    req[i][0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    plan[0].push_back(mk(1'b0, 16'h0020, '0));
    run(i, 0);
    // Back-to-back requests from both ports: grants alternate.
    for (int k = 0; k < 4; k++) begin
      plan[0].push_back(mk(1'b0, 16'h0040, '0));
      plan[1].push_back(mk(1'b0, 16'h0010, '0));
    end
    run(i, 0);
    // Random traffic over a small address pool with collisions.
    for (int k = 0; k < 40; k++)
      for (int p = 0; p < 2; p++) begin
        a = 16'($urandom_range(0, 3));
        a = (a << 14) | 16'($urandom_range(0, 15));
        plan[p].push_back(mk(1'($urandom_range(0, 1)), a, $urandom));
      end
    run(i, 2);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 1'b0; we[i][p] = 1'b0; addr[i][p] = '0; wdata[i][p] = '0;
      end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 2; i++) program_inst(i);
    repeat (4) @(posedge clk);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
